regfile_writeback_arbiter: RTL and testbench
============================================

// Module: regfile_writeback_arbiter
// PURPOSE
//   Shares the register file's single write port between NUM_REQ writeback sources
//   (e.g. ALU, load unit, multiplier) using round-robin arbitration.
//   Keeps a busy scoreboard so issue logic can stall on pending destination writes.
//   Sits between the execute/memory units and the register file write port.
// PARAMETERS
//   NUM_REQ    3   number of writeback requesters (>=2)
//   REG_COUNT  32  architectural registers; register 0 is hardwired zero
//   REG_WIDTH  32  data width of a register
// PORTS
//   clk          in   1                        clock, rising edge
//   reset        in   1                        asynchronous, active-high
//   req_valid    in   NUM_REQ                  requester i has a writeback pending
//   req_rd       in   NUM_REQ x log2(REG_COUNT) destination register per requester
//   req_value    in   NUM_REQ x REG_WIDTH      writeback data per requester
//   req_ready    out  NUM_REQ                  one-hot grant; transfer = valid & ready
//   rsv_valid    in   1                        issue stage reserves a destination
//   rsv_rd       in   log2(REG_COUNT)          register being reserved
//   rsv_ready    out  1                        reservation accepted this cycle
//   busy         out  REG_COUNT                scoreboard; bit r = write to r outstanding
//   rf_rd        out  log2(REG_COUNT)          register file write address (registered)
//   rf_rd_value  out  REG_WIDTH                register file write data (registered)
//   rf_wr_en     out  1                        register file write enable (registered)
// BEHAVIOUR
//   Reset (async): rr pointer=0, busy='0, rf_rd=0, rf_rd_value=0, rf_wr_en=0.
//   Arbitration
//   - Combinational each cycle. Search starts at pointer p, then p+1 .. wraps modulo NUM_REQ.
//   - The first valid requester gets req_ready=1. At most one ready bit is high.
//   - After a grant to i: p <= (i+1) mod NUM_REQ. With no valid requester, p holds.
//   - req_ready does not depend on req_rd/req_value.
//   - A requester must hold valid, rd and value stable until it is granted.
//   Write stage
//   - 1-cycle latency, always accepts.
//   - On grant to i: rf_rd <= req_rd[i], rf_rd_value <= req_value[i],
//     rf_wr_en <= (req_rd[i] != 0).
//   - No grant: rf_wr_en <= 0; rf_rd and rf_rd_value hold.
//   - Outputs change only on the rising edge, so they are stable for the
//     register file's falling-edge write.
//   - A grant with rd=0 is consumed (handshake completes) but nothing is written.
//   Scoreboard
//   - rsv_ready = rsv_valid & ~busy[rsv_rd] & (rsv_rd != 0).
//   - Accepted reservation: busy[rsv_rd] <= 1.
//   - Grant to rd=r: busy[r] <= 0 on the same edge the write stage loads.
//   - Same-cycle reserve and clear of the same r: cannot happen, because
//     rsv_ready=0 while busy[r]. There is no same-cycle bypass.
//   - A grant to a non-busy r is legal; busy stays 0.
//   - busy[0] is always 0.
//   Reset mid-operation: all state clears immediately. Any in-flight write
//   (rf_wr_en) is dropped and requesters re-present after reset.
// STRUCTURE
//   Shared package gpu_regfile_pkg:
//   - REG_COUNT, REG_WIDTH, REG_ADDR_W = $clog2(REG_COUNT)
//   - typedefs reg_addr_t, reg_data_t
//   - struct wb_req_t {reg_addr_t rd; reg_data_t value;}
//   Sub-module rr_arbiter #(N): req[N] -> grant[N] one-hot plus pointer update.
//   It is reusable for the memory port. Scoreboard and write stage stay in this module.
// TESTING
//   1 Reset: assert reset mid-grant -> rf_wr_en=0, busy=0, pointer=0 at once, async.
//   2 All 3 valid continuously, rd=5/6/7 -> grants 0,1,2,0,...
//     rf_wr_en=1 each cycle one cycle after each grant, rf_rd=5,6,7.
//   3 Only req1 valid (rd=3, value=0xDEADBEEF) -> req_ready=3'b010 same cycle;
//     next cycle rf_rd=3, rf_rd_value=0xDEADBEEF, rf_wr_en=1; then rf_wr_en=0.
//   4 Reserve r9 -> busy[9]=1. Second reserve of r9 -> rsv_ready=0.
//     Grant write to r9 -> busy[9]=0 after the edge; reserve r9 then succeeds.
//   5 Request with rd=0 -> handshake completes, rf_wr_en=0.
//     rsv_rd=0 -> rsv_ready=0, busy[0] stays 0.
//   6 Pointer=2 with req0 and req2 valid -> req2 granted first, then req0.
//     Idle cycles keep the pointer unchanged.

Source files
------------

// File: rtl/gpu_regfile_pkg.sv
// Shared register-file types used by writeback and issue logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: REG_COUNT/REG_WIDTH/REG_ADDR_W, reg_addr_t, reg_data_t, wb_req_t.
package gpu_regfile_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_WIDTH  = 32;
  localparam int REG_ADDR_W = $clog2(REG_COUNT);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_WIDTH-1:0]  reg_data_t;

  typedef struct packed {
    reg_addr_t rd;
    reg_data_t value;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among N requesters, search starts at pointer.
// Latency: grant is combinational; pointer advances on the granting edge.
// Backpressure: a requester without a grant simply waits; pointer holds when idle.
// Ports: clk, reset (async, active-high), req[N] in, grant[N] out (one-hot or zero).
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic          found;
  int            idx;

  // Walk the requesters starting at ptr; the first valid one wins and the
  // pointer moves just past it so it becomes lowest priority next time.
  always_comb begin
    grant    = '0;
    ptr_next = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_next   = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr <= '0;
    else       ptr <= ptr_next;
  end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Shares the single register-file write port among NUM_REQ writeback sources
// (round-robin) and keeps a per-register busy scoreboard for issue stalls.
// Latency: 1 cycle grant-to-write; backpressure: un-granted requesters hold valid.
// Ports: req_valid/req_rd/req_value -> req_ready (one-hot grant);
//        rsv_valid/rsv_rd -> rsv_ready; busy[REG_COUNT]; rf_rd/rf_rd_value/rf_wr_en
//        are registered toward the register file write port.
module regfile_writeback_arbiter
  import gpu_regfile_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic      [NUM_REQ-1:0]      req_valid,
  input  reg_addr_t [NUM_REQ-1:0]      req_rd,
  input  reg_data_t [NUM_REQ-1:0]      req_value,
  output logic      [NUM_REQ-1:0]      req_ready,
  input  logic                         rsv_valid,
  input  reg_addr_t                    rsv_rd,
  output logic                         rsv_ready,
  output logic      [REG_COUNT-1:0]    busy,
  output reg_addr_t                    rf_rd,
  output reg_data_t                    rf_rd_value,
  output logic                         rf_wr_en
);

  wb_req_t                win;
  logic                   win_vld;
  logic [REG_COUNT-1:0]   busy_next;

  // Grant depends only on req_valid, never on the payload.
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_valid),
    .grant (req_ready)
  );

  // One-hot select of the winning payload.
  always_comb begin
    win     = '0;
    win_vld = |req_ready;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        win.rd    = req_rd[i];
        win.value = req_value[i];
      end
    end
  end

  // A register can only be reserved when no write to it is outstanding;
  // r0 is never tracked because writes to it are discarded.
  assign rsv_ready = rsv_valid & ~busy[rsv_rd] & (rsv_rd != '0);

  // Clear from the granted write, then set from an accepted reservation.
  // The two never target the same busy register in one cycle because
  // rsv_ready is low while that register is busy.
  always_comb begin
    busy_next = busy;
    if (win_vld)   busy_next[win.rd] = 1'b0;
    if (rsv_ready) busy_next[rsv_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy        <= '0;
      rf_rd       <= '0;
      rf_rd_value <= '0;
      rf_wr_en    <= 1'b0;
    end else begin
      busy <= busy_next;
      if (win_vld) begin
        rf_rd       <= win.rd;
        rf_rd_value <= win.value;
        // A grant to r0 completes the handshake but writes nothing.
        rf_wr_en    <= (win.rd != '0);
      end else begin
        rf_wr_en    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
module tb_regfile_writeback_arbiter;
  import gpu_regfile_pkg::*;

  localparam int NR = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic      [NR-1:0]    req_valid;
  reg_addr_t [NR-1:0]    req_rd;
  reg_data_t [NR-1:0]    req_value;
  logic      [NR-1:0]    req_ready;
  logic                  rsv_valid;
  reg_addr_t             rsv_rd;
  logic                  rsv_ready;
  logic [REG_COUNT-1:0]  busy;
  reg_addr_t             rf_rd;
  reg_data_t             rf_rd_value;
  logic                  rf_wr_en;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int                    m_ptr;
  logic [REG_COUNT-1:0]  m_busy;
  reg_addr_t             m_rf_rd;
  reg_data_t             m_rf_val;
  logic                  m_wr_en;

  always #5 clk = ~clk;

  regfile_writeback_arbiter #(.NUM_REQ(NR)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rd(req_rd), .req_value(req_value), .req_ready(req_ready),
    .rsv_valid(rsv_valid), .rsv_rd(rsv_rd), .rsv_ready(rsv_ready),
    .busy(busy), .rf_rd(rf_rd), .rf_rd_value(rf_rd_value), .rf_wr_en(rf_wr_en)
  );

  // Lowest valid index at or above the pointer, else lowest valid index overall.
  function automatic int exp_grant();
    for (int i = m_ptr; i < NR; i++) if (req_valid[i]) return i;
    for (int i = 0; i < m_ptr; i++) if (req_valid[i]) return i;
    return -1;
  endfunction

  function automatic logic [NR-1:0] exp_ready();
    logic [NR-1:0] r;
    int g;
    r = '0;
    g = exp_grant();
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic exp_rsv();
    return rsv_valid && !m_busy[rsv_rd] && (rsv_rd != 0);
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_busy = '0; m_rf_rd = '0; m_rf_val = '0; m_wr_en = 1'b0;
  endtask

  task automatic model_edge();
    int   g;
    logic ok;
    g  = exp_grant();
    ok = exp_rsv();
    if (g >= 0) begin
      m_rf_rd  = req_rd[g];
      m_rf_val = req_value[g];
      m_wr_en  = (req_rd[g] != 0);
      m_busy[req_rd[g]] = 1'b0;
      m_ptr = (g + 1) % NR;
    end else begin
      m_wr_en = 1'b0;
    end
    if (ok) m_busy[rsv_rd] = 1'b1;
  endtask

  // Advance one clock; ends 1 time unit after the rising edge.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0; rsv_valid = 1'b0; rsv_rd = '0;
    for (int i = 0; i < NR; i++) begin req_rd[i] = '0; req_value[i] = '0; end
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (rf_wr_en !== 1'b0 || busy !== '0 || rf_rd !== '0 || rf_rd_value !== '0) begin
      n_err++; $display("FAIL reset_state: wr_en=%b busy=%h rd=%0d val=%h want 0/0/0/0", rf_wr_en, busy, rf_rd, rf_rd_value); end
    rsv_valid = 1'b1; rsv_rd = 5'd4;
    req_valid = 3'b111; req_rd[0] = 5'd5; req_rd[1] = 5'd6; req_rd[2] = 5'd7;
    req_value[0] = 32'h11; req_value[1] = 32'h22; req_value[2] = 32'h33;
    tick();
    rsv_valid = 1'b0;
    n_cmp++; if (rf_wr_en !== 1'b1 || busy[4] !== 1'b1) begin
      n_err++; $display("FAIL reset_pre: wr_en=%b busy4=%b want 1/1", rf_wr_en, busy[4]); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (rf_wr_en !== 1'b0 || busy !== '0 || rf_rd !== '0 || rf_rd_value !== '0) begin
      n_err++; $display("FAIL reset_async: wr_en=%b busy=%h rd=%0d val=%h want 0/0/0/0", rf_wr_en, busy, rf_rd, rf_rd_value); end
    reset = 1'b0;
    model_reset();
    #2;
    n_cmp++; if (req_ready !== 3'b001) begin
      n_err++; $display("FAIL reset_ptr: req_ready=%b want 001", req_ready); end
    tick();
    idle_inputs();
  endtask

  task automatic test_all_valid();
    do_reset();
    req_valid = 3'b111;
    for (int i = 0; i < NR; i++) begin req_rd[i] = reg_addr_t'(5 + i); req_value[i] = $urandom; end
    for (int k = 0; k < 9; k++) begin
      int        g;
      reg_data_t v;
      g = k % NR;
      v = req_value[g];
      #3;
      n_cmp++; if (req_ready !== (3'b001 << g)) begin
        n_err++; $display("FAIL rr_grant k=%0d: req_ready=%b want %b", k, req_ready, 3'b001 << g); end
      tick();
      n_cmp++; if (rf_wr_en !== 1'b1 || rf_rd !== reg_addr_t'(5 + g) || rf_rd_value !== v) begin
        n_err++; $display("FAIL rr_write k=%0d: wr_en=%b rd=%0d val=%h want 1/%0d/%h", k, rf_wr_en, rf_rd, rf_rd_value, 5 + g, v); end
      req_value[g] = $urandom;
    end
    idle_inputs();
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 3'b010; req_rd[1] = 5'd3; req_value[1] = 32'hDEADBEEF;
    #3;
    n_cmp++; if (req_ready !== 3'b010) begin
      n_err++; $display("FAIL single_ready: req_ready=%b want 010", req_ready); end
    tick();
    req_valid = '0;
    n_cmp++; if (rf_rd !== 5'd3 || rf_rd_value !== 32'hDEADBEEF || rf_wr_en !== 1'b1) begin
      n_err++; $display("FAIL single_write: rd=%0d val=%h wr_en=%b want 3/deadbeef/1", rf_rd, rf_rd_value, rf_wr_en); end
    tick();
    n_cmp++; if (rf_wr_en !== 1'b0 || rf_rd !== 5'd3 || rf_rd_value !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL single_idle: wr_en=%b rd=%0d val=%h want 0/3/deadbeef", rf_wr_en, rf_rd, rf_rd_value); end
  endtask

  task automatic test_scoreboard();
    do_reset();
    rsv_valid = 1'b1; rsv_rd = 5'd9;
    #3;
    n_cmp++; if (rsv_ready !== 1'b1) begin
      n_err++; $display("FAIL rsv_first: rsv_ready=%b want 1", rsv_ready); end
    tick();
    n_cmp++; if (busy !== (32'h1 << 9)) begin
      n_err++; $display("FAIL rsv_busy: busy=%h want %h", busy, 32'h1 << 9); end
    #3;
    n_cmp++; if (rsv_ready !== 1'b0) begin
      n_err++; $display("FAIL rsv_second: rsv_ready=%b want 0", rsv_ready); end
    tick();
    rsv_valid = 1'b0;
    req_valid = 3'b001; req_rd[0] = 5'd9; req_value[0] = 32'hCAFE0009;
    tick();
    req_valid = '0;
    n_cmp++; if (busy[9] !== 1'b0 || rf_wr_en !== 1'b1 || rf_rd !== 5'd9) begin
      n_err++; $display("FAIL rsv_clear: busy9=%b wr_en=%b rd=%0d want 0/1/9", busy[9], rf_wr_en, rf_rd); end
    rsv_valid = 1'b1; rsv_rd = 5'd9;
    #3;
    n_cmp++; if (rsv_ready !== 1'b1) begin
      n_err++; $display("FAIL rsv_again: rsv_ready=%b want 1", rsv_ready); end
    tick();
    idle_inputs();
  endtask

  task automatic test_rd_zero();
    do_reset();
    req_valid = 3'b100; req_rd[2] = 5'd0; req_value[2] = 32'h12345678;
    #3;
    n_cmp++; if (req_ready !== 3'b100) begin
      n_err++; $display("FAIL rd0_ready: req_ready=%b want 100", req_ready); end
    tick();
    req_valid = '0;
    n_cmp++; if (rf_wr_en !== 1'b0) begin
      n_err++; $display("FAIL rd0_write: wr_en=%b want 0", rf_wr_en); end
    rsv_valid = 1'b1; rsv_rd = 5'd0;
    #3;
    n_cmp++; if (rsv_ready !== 1'b0) begin
      n_err++; $display("FAIL rsv0_ready: rsv_ready=%b want 0", rsv_ready); end
    tick();
    n_cmp++; if (busy !== '0) begin
      n_err++; $display("FAIL rsv0_busy: busy=%h want 0", busy); end
    idle_inputs();
  endtask

  task automatic test_pointer();
    do_reset();
    req_valid = 3'b010; req_rd[1] = 5'd1;
    tick();
    req_valid = 3'b101; req_rd[0] = 5'd10; req_rd[2] = 5'd12;
    #3;
    n_cmp++; if (req_ready !== 3'b100) begin
      n_err++; $display("FAIL ptr2_first: req_ready=%b want 100", req_ready); end
    tick();
    req_valid = 3'b001;
    #3;
    n_cmp++; if (req_ready !== 3'b001) begin
      n_err++; $display("FAIL ptr2_second: req_ready=%b want 001", req_ready); end
    tick();
    req_valid = '0;
    for (int k = 0; k < 4; k++) tick();
    req_valid = 3'b011;
    #3;
    n_cmp++; if (req_ready !== 3'b010) begin
      n_err++; $display("FAIL ptr_idle_hold: req_ready=%b want 010", req_ready); end
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      int g;
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_rd[i]    = reg_addr_t'($urandom_range(0, REG_COUNT - 1));
          req_value[i] = $urandom;
        end
      end
      rsv_valid = ($urandom_range(0, 2) == 0);
      rsv_rd    = reg_addr_t'($urandom_range(0, REG_COUNT - 1));
      #3;
      n_cmp++; if (req_ready !== exp_ready() || rsv_ready !== exp_rsv()) begin
        n_err++; $display("FAIL rnd_comb c=%0d: ready=%b rsv=%b want %b/%b", c, req_ready, rsv_ready, exp_ready(), exp_rsv()); end
      g = exp_grant();
      tick();
      n_cmp++; if (rf_wr_en !== m_wr_en || rf_rd !== m_rf_rd || rf_rd_value !== m_rf_val || busy !== m_busy) begin
        n_err++; $display("FAIL rnd_regs c=%0d: wr_en=%b rd=%0d val=%h busy=%h want %b/%0d/%h/%h",
                          c, rf_wr_en, rf_rd, rf_rd_value, busy, m_wr_en, m_rf_rd, m_rf_val, m_busy); end
      if (g >= 0) req_valid[g] = 1'b0;
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_all_valid();
    test_single();
    test_scoreboard();
    test_rd_zero();
    test_pointer();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
